// File: rtl/chan_capture_pkg.sv
// Shared types and parameter limits for the multi-channel capture pipeline.
package chan_capture_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        ACCUM   = 2'd1,
        XOR     = 2'd2,
        HOLD    = 2'd3
    } mode_e;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 32;
    localparam int DEPTH_MIN    = 1;
    localparam int DEPTH_MAX    = 4;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 8;

endpackage

// File: rtl/chan_capture_lane.sv
// One channel: accumulator, sticky carry flag and a DEPTH-stage valid/ready pipe.
module chan_capture_lane
    import chan_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  mode_e            mode,
    input  logic             accept_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             ovf
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0]            rdy;
    logic [WIDTH-1:0]            acc, acc_nx, stage0_d;
    logic [WIDTH:0]              sum;
    logic                        carry, fire, ovf_q;

    // A stage can load if any stage from it to the output has a hole, or the sink takes a beat.
    // Written without a ripple chain so each bit depends only on state and out_ready.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
        assign rdy[k] = out_ready || !(&vld[DEPTH-1:k]);
    end

    assign in_ready  = accept_en && rdy[0];
    assign fire      = in_valid && in_ready;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign ovf       = ovf_q;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, in_data};
        acc_nx = acc;
        carry  = 1'b0;
        case (mode)
            ACCUM: begin
                acc_nx = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            XOR:     acc_nx = acc ^ in_data;
            default: acc_nx = acc;
        endcase
        stage0_d = (mode == CAPTURE) ? in_data : acc_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld   <= '0;
            dat   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            vld   <= '0;
            dat   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (fire) begin
                acc <= acc_nx;
                if (carry) ovf_q <= 1'b1;
            end
            if (rdy[0]) begin
                vld[0] <= fire;
                if (fire) dat[0] <= stage0_d;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) dat[k] <= dat[k-1];
                end
            end
        end
    end

    // Shadow of CAPTURE beats that saw an unstalled path; only feeds the latency assertion.
    logic [DEPTH:1]            chk_v;
    logic [DEPTH:1][WIDTH-1:0] chk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_v <= '0;
            chk_d <= '0;
        end else begin
            chk_v[1] <= fire && (mode == CAPTURE) && !clear;
            chk_d[1] <= in_data;
            for (int k = 2; k <= DEPTH; k++) begin
                chk_v[k] <= chk_v[k-1] && out_ready && !clear;
                chk_d[k] <= chk_d[k-1];
            end
        end
    end

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_data)));

    a_capture_latency: assert property (@(posedge clk) disable iff (reset)
        chk_v[DEPTH] |-> (out_valid && out_data == chk_d[DEPTH]));

endmodule

// File: rtl/chan_capture_pipe.sv
// CHANNELS independent capture/accumulate pipelines sharing a global mode and clear.
module chan_capture_pipe
    import chan_capture_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS-1:0]       ovf
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_params
        $error("chan_capture_pipe: parameter out of range");
    end

    mode_e mode_q;
    logic  accept_en;

    assign mode_q    = mode_e'(mode);
    assign accept_en = !reset && !clear && (mode_q != HOLD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        chan_capture_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .mode      (mode_q),
            .accept_en (accept_en),
            .in_valid  (in_valid[c]),
            .in_data   (in_data[c*WIDTH +: WIDTH]),
            .in_ready  (in_ready[c]),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*WIDTH +: WIDTH]),
            .out_ready (out_ready[c]),
            .ovf       (ovf[c])
        );
    end

endmodule

// File: tb/tb_chan_capture_pipe.sv
// Self-checking bench for chan_capture_pipe (WIDTH=8, DEPTH=2, CHANNELS=4).
module tb_chan_capture_pipe;
    import chan_capture_pkg::*;

    localparam int W = 8;
    localparam int D = 2;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           reset, clear;
    logic [1:0]     mode;
    logic [C-1:0]   in_valid, in_ready, out_valid, out_ready, ovf;
    logic [C*W-1:0] in_data, out_data;

    chan_capture_pipe #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sbq [C][$];
    logic [C-1:0] obs_acc, obs_ov, obs_ir;

    typedef struct {
        logic [1:0] md;
        int         ch;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int ch, input logic [7:0] v);
        logic [31:0] r;
        r = 32'(v) << (ch * 8);
        return r;
    endfunction

    // Drive one cycle at the negedge, sample just after, score, then leave the posedge to come.
    task automatic step(input logic [1:0] md, input logic [3:0] iv, input logic [31:0] id,
                        input logic [3:0] ordy, input logic clr, input logic [31:0] ex);
        @(negedge clk);
        mode = md; in_valid = iv; in_data = id; out_ready = ordy; clear = clr;
        #1;
        obs_acc = in_valid & in_ready;
        obs_ov  = out_valid;
        obs_ir  = in_ready;
        for (int c = 0; c < C; c++) begin
            if (out_valid[c] && out_ready[c]) begin
                if (sbq[c].size() == 0)
                    chk($sformatf("ch%0d unexpected beat", c), {24'h0, out_data[c*W +: W]}, 32'hDEAD);
                else
                    chk($sformatf("ch%0d data", c), {24'h0, out_data[c*W +: W]}, {24'h0, sbq[c].pop_front()});
            end
            if (obs_acc[c]) sbq[c].push_back(ex[c*W +: W]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(CAPTURE, 4'h0, 32'h0, 4'hF, 1'b0, 32'h0);
    endtask

    task automatic flush_sb();
        for (int c = 0; c < C; c++) sbq[c].delete();
    endtask

    initial begin
        logic [7:0] seq [3];
        logic [7:0] held;
        int idx2, n0;
        bit seen;

        reset = 1'b1; clear = 1'b0; mode = CAPTURE;
        in_valid = 4'hF; in_data = 32'hFFFF_FFFF; out_ready = 4'hF;
        #12;
        chk("reset out_valid", {28'h0, out_valid}, 32'h0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset ovf", {28'h0, ovf}, 32'h0);
        chk("reset in_ready", {28'h0, in_ready}, 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        in_valid = 4'h0;

        // CAPTURE latency and back-to-back throughput on ch0
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(CAPTURE, 4'h1, pk(0, seq[i]), 4'hF, 1'b0, pk(0, seq[i]));
            else       step(CAPTURE, 4'h0, 32'h0, 4'hF, 1'b0, 32'h0);
            if (i < 3) chk($sformatf("cap accept %0d", i), {31'h0, obs_acc[0]}, 32'h1);
            chk($sformatf("cap latency ov0 %0d", i), {31'h0, obs_ov[0]}, (i >= 2) ? 32'h1 : 32'h0);
        end

        // Mixed-mode vectors; mode changes between rows only affect later beats
        tbl[0] = '{CAPTURE, 0, 8'hAA, 8'hAA};
        tbl[1] = '{ACCUM,   1, 8'hF0, 8'hF0};
        tbl[2] = '{ACCUM,   1, 8'h20, 8'h10};
        tbl[3] = '{XOR,     3, 8'h0F, 8'h0F};
        tbl[4] = '{XOR,     3, 8'hFF, 8'hF0};
        tbl[5] = '{CAPTURE, 2, 8'h7E, 8'h7E};
        tbl[6] = '{ACCUM,   0, 8'h01, 8'h01};
        tbl[7] = '{XOR,     0, 8'h03, 8'h02};
        tbl[8] = '{CAPTURE, 3, 8'h5A, 8'h5A};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].md, 4'(1 << tbl[i].ch), pk(tbl[i].ch, tbl[i].din), 4'hF, 1'b0,
                 pk(tbl[i].ch, tbl[i].exp));
            chk($sformatf("tbl accept %0d", i), {28'h0, obs_acc}, 32'(1 << tbl[i].ch));
        end
        idle(3);
        chk("accum ovf", {28'h0, ovf}, 32'h2);

        // XOR on ch3 (acc=F0) then HOLD: no accepts, in-flight beats drain
        step(XOR, 4'h8, pk(3, 8'h0F), 4'hF, 1'b0, pk(3, 8'hFF));
        step(XOR, 4'h8, pk(3, 8'hFF), 4'hF, 1'b0, pk(3, 8'h00));
        for (int i = 0; i < 4; i++) begin
            step(HOLD, 4'h9, pk(3, 8'h55) | pk(0, 8'h55), 4'hF, 1'b0, 32'h0);
            chk($sformatf("hold in_ready %0d", i), {28'h0, obs_ir}, 32'h0);
            chk($sformatf("hold drain ov3 %0d", i), {31'h0, obs_ov[3]}, (i < 2) ? 32'h1 : 32'h0);
        end

        // Backpressure on ch2 while ch0 keeps flowing
        idx2 = 0; n0 = 0; seen = 0; held = '0;
        for (int i = 0; i < 5; i++) begin
            step(CAPTURE, (idx2 < 4) ? 4'h5 : 4'h1,
                 pk(2, 8'hA1 + 8'(idx2)) | pk(0, 8'h40 + 8'(i)), 4'hB, 1'b0,
                 pk(2, 8'hA1 + 8'(idx2)) | pk(0, 8'h40 + 8'(i)));
            if (obs_acc[2]) idx2++;
            if (obs_acc[0]) n0++;
            if (obs_ov[2]) begin
                if (!seen) begin held = out_data[2*W +: W]; seen = 1; end
                else chk($sformatf("bp stable %0d", i), {24'h0, out_data[2*W +: W]}, {24'h0, held});
            end
        end
        chk("bp accepted", 32'(idx2), 32'(D));
        chk("bp out_valid seen", {31'h0, seen}, 32'h1);
        chk("bp ch0 flow", 32'(n0), 32'd5);
        for (int i = 0; i < 8; i++) begin
            step(CAPTURE, (idx2 < 4) ? 4'h4 : 4'h0, pk(2, 8'hA1 + 8'(idx2)), 4'hF, 1'b0,
                 pk(2, 8'hA1 + 8'(idx2)));
            if (obs_acc[2]) idx2++;
        end
        chk("bp all accepted", 32'(idx2), 32'd4);
        chk("bp ch2 drained", 32'(sbq[2].size()), 32'd0);

        // clear with two ch1 beats in flight and a same-cycle offer
        step(ACCUM, 4'h2, pk(1, 8'h03), 4'hD, 1'b0, pk(1, 8'h13));
        step(ACCUM, 4'h2, pk(1, 8'h04), 4'hD, 1'b0, pk(1, 8'h17));
        chk("clr preload", {28'h0, obs_acc}, 32'h2);
        step(ACCUM, 4'h3, pk(1, 8'h09) | pk(0, 8'h09), 4'hD, 1'b1, 32'h0);
        chk("clr in_ready", {28'h0, obs_ir}, 32'h0);
        flush_sb();
        for (int i = 0; i < 3; i++) begin
            step(ACCUM, 4'h0, 32'h0, 4'hF, 1'b0, 32'h0);
            chk($sformatf("clr no output %0d", i), {28'h0, obs_ov}, 32'h0);
            chk($sformatf("clr ovf %0d", i), {28'h0, ovf}, 32'h0);
        end
        step(ACCUM, 4'h2, pk(1, 8'h05), 4'hF, 1'b0, pk(1, 8'h05));
        chk("clr next accept", {28'h0, obs_acc}, 32'h2);
        idle(3);
        chk("clr ch1 drained", 32'(sbq[1].size()), 32'd0);

        // Reset mid-stream with ch0 stalled at the output
        step(CAPTURE, 4'h1, pk(0, 8'hAA), 4'hE, 1'b0, pk(0, 8'hAA));
        step(CAPTURE, 4'h1, pk(0, 8'hBB), 4'hE, 1'b0, pk(0, 8'hBB));
        step(CAPTURE, 4'h0, 32'h0, 4'hE, 1'b0, 32'h0);
        chk("rst pre ov0", {31'h0, obs_ov[0]}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rst out_valid", {28'h0, out_valid}, 32'h0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst in_ready", {28'h0, in_ready}, 32'h0);
        flush_sb();
        @(posedge clk); #2;
        reset = 1'b0;
        step(CAPTURE, 4'h1, pk(0, 8'h5C), 4'hF, 1'b0, pk(0, 8'h5C));
        chk("rst first accept", {31'h0, obs_acc[0]}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(CAPTURE, 4'h0, 32'h0, 4'hF, 1'b0, 32'h0);
            chk($sformatf("rst post ov %0d", i), {28'h0, obs_ov}, (i == 1) ? 32'h1 : 32'h0);
        end

        for (int c = 0; c < C; c++)
            chk($sformatf("final ch%0d queue", c), 32'(sbq[c].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
